// File: rtl/lfsr_prbs_gen_stream.sv
// rtl/lfsr_prbs_gen_stream.sv - Streaming PRBS word generator with burst, stop and error injection
// Contains the combinational lfsr stepper and the valid/ready PRBS stream front end.

module lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter int                    LFSR_FEED_FORWARD = 0,
  parameter int                    REVERSE           = 0,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int N = LFSR_WIDTH + DATA_WIDTH;
  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_POLY >> 1;

  typedef logic [N-1:0][N-1:0] mat_t;

  // Bit-serial reference: MSB of the word is the first bit in time unless REVERSE.
  function automatic logic [N-1:0] lfsr_eval(input logic [LFSR_WIDTH-1:0] s_in,
                                             input logic [DATA_WIDTH-1:0] d_in);
    logic [LFSR_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] d;
    logic                  fb;
    logic                  din;
    int                    idx;
    s = s_in;
    d = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      idx = (REVERSE != 0) ? DATA_WIDTH - 1 - i : i;
      din = d_in[idx];
      if (LFSR_CONFIG == "GALOIS") begin
        fb     = s[LFSR_WIDTH-1] ^ din;
        d[idx] = fb;
        s      = {s[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
      end else begin
        fb     = s[LFSR_WIDTH-1] ^ (^(s & TAPS));
        d[idx] = fb ^ din;
        s      = {s[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD != 0) ? din : (fb ^ din)};
      end
    end
    return {s, d};
  endfunction

  // The stepper is linear over GF(2), so its response to each one-hot input gives the XOR masks.
  function automatic mat_t build_masks();
    mat_t           m;
    logic [N-1:0]   e;
    logic [N-1:0]   y;
    m = '0;
    for (int k = 0; k < N; k++) begin
      e    = '0;
      e[k] = 1'b1;
      y    = lfsr_eval(e[LFSR_WIDTH-1:0], e[N-1:LFSR_WIDTH]);
      for (int o = 0; o < N; o++) begin
        m[o][k] = y[o];
      end
    end
    return m;
  endfunction

  logic [N-1:0] result;

  if (STYLE == "LOOP") begin : g_loop
    assign result = lfsr_eval(state_in, data_in);
  end else begin : g_reduce
    localparam mat_t MASKS = build_masks();
    logic [N-1:0] x;
    assign x = {data_in, state_in};
    for (genvar o = 0; o < N; o++) begin : g_bit
      assign result[o] = ^(MASKS[o] & x);
    end
  end

  assign data_out  = result[DATA_WIDTH-1:0];
  assign state_out = result[N-1:DATA_WIDTH];

endmodule

module lfsr_prbs_gen_stream #(
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
  parameter int                    REVERSE     = 0,
  parameter int                    INVERT      = 1,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO",
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  input  logic                   inject_err,
  input  logic [DATA_WIDTH-1:0]  err_mask,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic                   inject_pending,
  output logic [COUNT_WIDTH-1:0] word_count
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} fsm_t;

  localparam logic [DATA_WIDTH-1:0]  INV_MASK = (INVERT != 0) ? '1 : '0;
  localparam logic [COUNT_WIDTH-1:0] ONE      = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  fsm_t                   fsm_reg, fsm_next;
  logic [LFSR_WIDTH-1:0]  state_reg;
  logic [DATA_WIDTH-1:0]  out_reg;
  logic [DATA_WIDTH-1:0]  mask_reg;
  logic                   pending_reg;
  logic [COUNT_WIDTH-1:0] count_reg, count_next, count_inc;
  logic [COUNT_WIDTH-1:0] burst_len_reg, burst_next;
  logic                   load, load_init, handshake;
  logic [LFSR_WIDTH-1:0]  seed, lfsr_state;
  logic [DATA_WIDTH-1:0]  lfsr_data, apply_mask;

  lfsr #(
    .LFSR_WIDTH        (LFSR_WIDTH),
    .LFSR_POLY         (LFSR_POLY),
    .LFSR_CONFIG       ("FIBONACCI"),
    .LFSR_FEED_FORWARD (0),
    .REVERSE           (REVERSE),
    .DATA_WIDTH        (DATA_WIDTH),
    .STYLE             (STYLE)
  ) u_lfsr (
    .data_in   ('0),
    .state_in  (seed),
    .data_out  (lfsr_data),
    .state_out (lfsr_state)
  );

  assign m_valid        = (fsm_reg != IDLE);
  assign busy           = m_valid;
  assign handshake      = m_valid & m_ready;
  assign count_inc      = count_reg + ONE;
  assign m_data         = out_reg;
  assign word_count     = count_reg;
  assign inject_pending = pending_reg;
  assign m_last         = m_valid & (burst_len_reg != '0) & (count_reg == burst_len_reg - ONE);

  // A same-cycle inject_err takes precedence so its fresh mask lands on this load.
  assign seed       = load_init ? LFSR_INIT : state_reg;
  assign apply_mask = inject_err ? err_mask : (pending_reg ? mask_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg <= IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  always_comb begin
    fsm_next   = fsm_reg;
    load       = 1'b0;
    load_init  = 1'b0;
    count_next = count_reg;
    burst_next = burst_len_reg;
    case (fsm_reg)
      IDLE: begin
        if (start && !stop) begin
          load       = 1'b1;
          load_init  = 1'b1;
          count_next = '0;
          burst_next = burst_len;
          fsm_next   = RUN;
        end
      end
      RUN: begin
        if (handshake) begin
          count_next = count_inc;
          if ((burst_len_reg != '0) && (count_inc == burst_len_reg)) begin
            fsm_next = IDLE;
          end else if (stop) begin
            fsm_next = IDLE;
          end else begin
            load = 1'b1;
          end
        end else if (stop) begin
          fsm_next = STOPPING;
        end
      end
      STOPPING: begin
        if (handshake) begin
          count_next = count_inc;
          fsm_next   = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LFSR_INIT;
      out_reg       <= '0;
      mask_reg      <= '0;
      pending_reg   <= 1'b0;
      count_reg     <= '0;
      burst_len_reg <= '0;
    end else begin
      count_reg     <= count_next;
      burst_len_reg <= burst_next;
      if (load) begin
        state_reg <= lfsr_state;
        out_reg   <= lfsr_data ^ INV_MASK ^ apply_mask;
      end
      if (inject_err) begin
        mask_reg <= err_mask;
      end
      if (load) begin
        pending_reg <= 1'b0;
      end else if (inject_err) begin
        pending_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_gen_stream.sv
// tb/tb_lfsr_prbs_gen_stream.sv - Scoreboard bench for lfsr_prbs_gen_stream with a bit-serial PRBS31 model
module tb_lfsr_prbs_gen_stream;

  localparam int DW = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          inject_err = 1'b0;
  logic [DW-1:0] err_mask = '0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          busy;
  logic          inject_pending;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  lfsr_prbs_gen_stream dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .burst_len      (burst_len),
    .inject_err     (inject_err),
    .err_mask       (err_mask),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .busy           (busy),
    .inject_pending (inject_pending),
    .word_count     (word_count)
  );

  int checks = 0;
  int passed = 0;

  bit            gen_bits[$];
  bit            chk_bits[$];
  logic [DW-1:0] exp_q[$];
  int            sb_hs, sb_underflow, sb_diff_words, sb_chk_err_bits, sb_last_bad, sb_last_idx;
  logic [DW-1:0] sb_diff_or;

  // PRBS31 recurrence b[n] = b[n-31] ^ b[n-28], history seeded with ones; words are inverted.
  function automatic void gen_reset();
    gen_bits.delete();
    repeat (31) gen_bits.push_back(1'b1);
  endfunction

  function automatic logic [DW-1:0] gen_word();
    logic [DW-1:0] w;
    bit            b;
    for (int i = DW - 1; i >= 0; i--) begin
      b = gen_bits[gen_bits.size() - 31] ^ gen_bits[gen_bits.size() - 28];
      gen_bits.push_back(b);
      w[i] = ~b;
      if (gen_bits.size() > 64) gen_bits.delete(0);
    end
    return w;
  endfunction

  function automatic void chk_reset();
    chk_bits.delete();
    repeat (31) chk_bits.push_back(1'b1);
  endfunction

  // Self-synchronising far-end checker: one flipped bit shows up at offsets 0, 28 and 31.
  function automatic logic [DW-1:0] chk_word(input logic [DW-1:0] w);
    logic [DW-1:0] e;
    bit            r;
    for (int i = DW - 1; i >= 0; i--) begin
      r    = ~w[i];
      e[i] = r ^ chk_bits[chk_bits.size() - 31] ^ chk_bits[chk_bits.size() - 28];
      chk_bits.push_back(r);
      if (chk_bits.size() > 64) chk_bits.delete(0);
    end
    return e;
  endfunction

  function automatic void sb_clear(input int last_idx);
    exp_q.delete();
    sb_hs = 0; sb_underflow = 0; sb_diff_words = 0; sb_chk_err_bits = 0; sb_last_bad = 0;
    sb_diff_or = '0;
    sb_last_idx = last_idx;
    gen_reset();
    chk_reset();
  endfunction

  // Called at a negedge where m_valid & m_ready, i.e. the word is taken on the next posedge.
  function automatic void sb_accept();
    logic [DW-1:0] exp_w;
    if (exp_q.size() == 0) begin
      sb_underflow++;
    end else begin
      exp_w = exp_q.pop_front();
      if (m_data !== exp_w) begin
        sb_diff_words++;
        sb_diff_or = sb_diff_or | (m_data ^ exp_w);
      end
    end
    sb_chk_err_bits += $countones(chk_word(m_data));
    if (m_last !== (sb_hs == sb_last_idx)) sb_last_bad++;
    sb_hs++;
  endfunction

  task automatic test_reset();
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else passed++;
    checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", m_data); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (inject_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", inject_pending); else passed++;
    checks++; if (word_count !== 32'd0) $display("FAIL reset_word_count got %0d want 0", word_count); else passed++;
  endtask

  task automatic test_loopback();
    int cyc;
    sb_clear(999);
    for (int i = 0; i < 1000; i++) exp_q.push_back(gen_word());
    @(negedge clk); start = 1'b1; burst_len = 1000; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (m_valid !== 1'b1) $display("FAIL loopback_latency m_valid got %b want 1", m_valid); else passed++;
    cyc = 0;
    while (m_valid === 1'b1 && cyc < 3000) begin
      if (m_ready) sb_accept();
      @(negedge clk); cyc++;
    end
    checks++; if (sb_hs !== 1000) $display("FAIL loopback_handshakes got %0d want 1000", sb_hs); else passed++;
    checks++; if (sb_diff_words !== 0) $display("FAIL loopback_data bad_words %0d want 0", sb_diff_words); else passed++;
    checks++; if (sb_chk_err_bits !== 0) $display("FAIL loopback_checker err_bits %0d want 0", sb_chk_err_bits); else passed++;
    checks++; if (sb_last_bad !== 0) $display("FAIL loopback_m_last bad %0d want 0", sb_last_bad); else passed++;
    checks++; if (word_count !== 32'd1000) $display("FAIL loopback_word_count got %0d want 1000", word_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL loopback_busy got %b want 0", busy); else passed++;
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int            cyc, stall_bad;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    sb_clear(-1);
    exp_q.push_back(gen_word());
    @(negedge clk); start = 1'b1; burst_len = 0; m_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0; stall_bad = 0; prev_stall = 1'b0; prev_data = '0;
    while (sb_hs < 10000 && cyc < 40000) begin
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_bad++;
      m_ready    = ($urandom_range(0, 1) == 1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        sb_accept();
        exp_q.push_back(gen_word());
      end
      @(negedge clk); cyc++;
    end
    m_ready = 1'b0; stop = 1'b1; prev_data = m_data;
    @(negedge clk); stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b1) $display("FAIL bp_stopping_valid got %b want 1", m_valid); else passed++;
    checks++; if (m_data !== prev_data) $display("FAIL bp_stopping_hold got %h want %h", m_data, prev_data); else passed++;
    m_ready = 1'b1;
    sb_accept();
    @(negedge clk); m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) $display("FAIL bp_stop_done got %b want 0", m_valid); else passed++;
    checks++; if (word_count !== 32'(sb_hs)) $display("FAIL bp_word_count got %0d want %0d", word_count, sb_hs); else passed++;
    checks++; if (stall_bad !== 0) $display("FAIL bp_stall_stable violations %0d want 0", stall_bad); else passed++;
    checks++; if (sb_diff_words !== 0) $display("FAIL bp_data bad_words %0d want 0", sb_diff_words); else passed++;
    checks++; if (sb_chk_err_bits !== 0) $display("FAIL bp_checker err_bits %0d want 0", sb_chk_err_bits); else passed++;
  endtask

  task automatic test_inject();
    sb_clear(-1);
    exp_q.push_back(gen_word());
    @(negedge clk); start = 1'b1; burst_len = 0; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sb_accept(); exp_q.push_back(gen_word());
      @(negedge clk);
    end
    m_ready = 1'b0; inject_err = 1'b1; err_mask = 8'h01;
    @(negedge clk); inject_err = 1'b0; err_mask = 8'h00;
    checks++; if (inject_pending !== 1'b1) $display("FAIL inj_pending_set got %b want 1", inject_pending); else passed++;
    m_ready = 1'b1;
    sb_accept(); exp_q.push_back(gen_word());
    @(negedge clk);
    checks++; if (inject_pending !== 1'b0) $display("FAIL inj_pending_clear got %b want 0", inject_pending); else passed++;
    for (int i = 0; i < 40; i++) begin
      sb_accept(); exp_q.push_back(gen_word());
      @(negedge clk);
    end
    stop = 1'b1; sb_accept();
    @(negedge clk); stop = 1'b0; m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) $display("FAIL inj_stop_valid got %b want 0", m_valid); else passed++;
    checks++; if (sb_diff_words !== 1) $display("FAIL inj_diff_words got %0d want 1", sb_diff_words); else passed++;
    checks++; if (sb_diff_or !== 8'h01) $display("FAIL inj_diff_bits got %h want 01", sb_diff_or); else passed++;
    checks++; if (sb_chk_err_bits !== 3) $display("FAIL inj_checker_bits got %0d want 3", sb_chk_err_bits); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] w0;
    @(negedge clk); start = 1'b1; stop = 1'b1; burst_len = 4;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL sim_start_stop_busy got %b want 0", busy); else passed++;

    sb_clear(4);
    for (int i = 0; i < 5; i++) exp_q.push_back(gen_word());
    @(negedge clk); start = 1'b1; burst_len = 5; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) stop = 1'b1;
      sb_accept();
      @(negedge clk);
    end
    stop = 1'b0; m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) $display("FAIL sim_final_stop_valid got %b want 0", m_valid); else passed++;
    checks++; if (word_count !== 32'd5) $display("FAIL sim_final_stop_count got %0d want 5", word_count); else passed++;
    checks++; if (sb_diff_words !== 0 || sb_last_bad !== 0)
      $display("FAIL sim_burst5 bad_words %0d bad_last %0d want 0 0", sb_diff_words, sb_last_bad); else passed++;

    gen_reset(); w0 = gen_word();
    @(negedge clk); start = 1'b1; burst_len = 1; m_ready = 1'b0; inject_err = 1'b1; err_mask = 8'h80;
    @(negedge clk); start = 1'b0; inject_err = 1'b0; err_mask = 8'h00;
    checks++; if (m_data !== (w0 ^ 8'h80)) $display("FAIL sim_inject_on_load got %h want %h", m_data, w0 ^ 8'h80); else passed++;
    checks++; if (inject_pending !== 1'b0) $display("FAIL sim_inject_on_load_pending got %b want 0", inject_pending); else passed++;
    m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL sim_burst1_busy got %b want 0", busy); else passed++;

    gen_reset(); w0 = gen_word();
    @(negedge clk); inject_err = 1'b1; err_mask = 8'h04;
    @(negedge clk); inject_err = 1'b0; err_mask = 8'h00;
    checks++; if (inject_pending !== 1'b1) $display("FAIL sim_idle_pending got %b want 1", inject_pending); else passed++;
    repeat (2) @(negedge clk);
    start = 1'b1; burst_len = 1; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (m_data !== (w0 ^ 8'h04)) $display("FAIL sim_idle_pending_word got %h want %h", m_data, w0 ^ 8'h04); else passed++;
    checks++; if (inject_pending !== 1'b0) $display("FAIL sim_idle_pending_clear got %b want 0", inject_pending); else passed++;
    @(negedge clk); m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] w0, first;
    gen_reset(); w0 = gen_word();
    @(negedge clk); start = 1'b1; burst_len = 100; m_ready = 1'b1;
    @(negedge clk); start = 1'b0; first = m_data;
    checks++; if (first !== w0) $display("FAIL rst_first_word got %h want %h", first, w0); else passed++;
    repeat (37) @(negedge clk);
    checks++; if (word_count !== 32'd37) $display("FAIL rst_at_word37 got %0d want 37", word_count); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", m_valid); else passed++;
    checks++; if (m_data !== 8'h00) $display("FAIL rst_mid_data got %h want 00", m_data); else passed++;
    checks++; if (busy !== 1'b0 || m_last !== 1'b0) $display("FAIL rst_mid_busy_last got %b%b want 00", busy, m_last); else passed++;
    checks++; if (word_count !== 32'd0) $display("FAIL rst_mid_count got %0d want 0", word_count); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1; burst_len = 100;
    @(negedge clk); start = 1'b0;
    checks++; if (m_data !== first) $display("FAIL rst_replay_word0 got %h want %h", m_data, first); else passed++;
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; m_ready = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL rst_replay_stop_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] seq [2][16];
    int            diff_runs, diff_model;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); start = 1'b1; burst_len = 16; m_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 16; k++) begin
        seq[r][k] = m_data;
        @(negedge clk);
      end
      m_ready = 1'b0;
    end
    diff_runs = 0; diff_model = 0;
    gen_reset();
    for (int k = 0; k < 16; k++) begin
      if (seq[0][k] !== seq[1][k]) diff_runs++;
      if (seq[0][k] !== gen_word()) diff_model++;
    end
    checks++; if (diff_runs !== 0) $display("FAIL b2b_runs_equal diff_words %0d want 0", diff_runs); else passed++;
    checks++; if (diff_model !== 0) $display("FAIL b2b_model diff_words %0d want 0", diff_model); else passed++;
    checks++; if (word_count !== 32'd16) $display("FAIL b2b_word_count got %0d want 16", word_count); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_backpressure();
    test_inject();
    test_simultaneous();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
